// File: rtl/rollover_counter.sv
// Programmable modulo counter that emits a one-cycle pulse on every wrap.
// New limits wait in a one-deep shadow register and are applied only at a wrap or while idle.
module rollover_counter #(
  parameter int WIDTH       = 8,
  parameter int RESET_LIMIT = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_limit_valid,
  output logic             o_limit_ready,
  output logic [WIDTH-1:0] o_count,
  output logic             o_roll_over,
  output logic [WIDTH-1:0] o_active_limit
);

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } shadow_state_t;

  shadow_state_t    state;
  shadow_state_t    state_next;
  logic [WIDTH-1:0] shadow;
  logic             accept;
  logic             apply;
  logic             at_limit;

  assign at_limit      = (o_count == o_active_limit);
  assign o_limit_ready = (state == EMPTY);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A pending limit is applied at an enabled wrap, or immediately if the counter is idle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    apply      = 1'b0;
    case (state)
      EMPTY: begin
        if (i_limit_valid) begin
          accept     = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (!i_enable || at_limit) begin
          apply      = 1'b1;
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Shadow data carries no reset; it is only read after a capture.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      shadow <= i_limit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_count        <= '0;
      o_roll_over    <= 1'b0;
      o_active_limit <= WIDTH'(RESET_LIMIT);
    end else begin
      if (i_enable) begin
        if (at_limit) begin
          o_count     <= '0;
          o_roll_over <= 1'b1;
        end else begin
          o_count     <= o_count + 1'b1;
          o_roll_over <= 1'b0;
        end
      end else begin
        o_roll_over <= 1'b0;
        if (apply) begin
          o_count <= '0;
        end
      end
      if (apply) begin
        o_active_limit <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_rollover_counter.sv
// Randomized and directed bench for rollover_counter against a cycle-level reference model.
module tb_rollover_counter;

  localparam int WIDTH       = 8;
  localparam int RESET_LIMIT = 9;

  logic             i_clk;
  logic             i_reset;
  logic             i_enable;
  logic [WIDTH-1:0] i_limit;
  logic             i_limit_valid;
  logic             o_limit_ready;
  logic [WIDTH-1:0] o_count;
  logic             o_roll_over;
  logic [WIDTH-1:0] o_active_limit;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_count   = 0;
  int m_roll    = 0;
  int m_active  = RESET_LIMIT;
  int m_pending = 0;
  int m_shadow  = 0;

  rollover_counter #(
    .WIDTH(WIDTH),
    .RESET_LIMIT(RESET_LIMIT)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_limit(i_limit),
    .i_limit_valid(i_limit_valid),
    .o_limit_ready(o_limit_ready),
    .o_count(o_count),
    .o_roll_over(o_roll_over),
    .o_active_limit(o_active_limit)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference model, using the inputs presented before the edge.
  task automatic model_edge();
    int acc;
    int app;
    if (i_reset) begin
      m_count   = 0;
      m_roll    = 0;
      m_active  = RESET_LIMIT;
      m_pending = 0;
      return;
    end
    acc = (m_pending == 0 && i_limit_valid) ? 1 : 0;
    app = (m_pending == 1 && (!i_enable || m_count == m_active)) ? 1 : 0;
    if (i_enable) begin
      if (m_count == m_active) begin
        m_count = 0;
        m_roll  = 1;
      end else begin
        m_count = (m_count + 1) % (1 << WIDTH);
        m_roll  = 0;
      end
    end else begin
      m_roll = 0;
    end
    if (app == 1) begin
      if (!i_enable) m_count = 0;
      m_active  = m_shadow;
      m_pending = 0;
    end
    if (acc == 1) begin
      m_shadow  = int'(i_limit);
      m_pending = 1;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    check("count", 32'(o_count), 32'(m_count));
    check("roll_over", 32'(o_roll_over), 32'(m_roll));
    check("active_limit", 32'(o_active_limit), 32'(m_active));
    check("limit_ready", 32'(o_limit_ready), 32'(m_pending == 0));
  endtask

  task automatic wait_count(input int value);
    int n;
    n = 0;
    while (o_count != value && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("wait_count_timeout", 32'(o_count), 32'(value));
  endtask

  task automatic offer(input int value);
    i_limit       = WIDTH'(value);
    i_limit_valid = 1'b1;
    step();
    i_limit_valid = 1'b0;
    i_limit       = WIDTH'($urandom);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_enable      = 1'b0;
    i_limit       = '0;
    i_limit_valid = 1'b0;
    step();
    step();
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_roll", 32'(o_roll_over), 32'd0);
    check("rst_active", 32'(o_active_limit), 32'(RESET_LIMIT));
    check("rst_ready", 32'(o_limit_ready), 32'd1);
    i_reset = 1'b0;

    // Plan 1: default period of 10, pulses at 10/20/30
    i_enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("t1_count", 32'(o_count), 32'(k % 10));
      check("t1_roll", 32'(o_roll_over), 32'((k % 10) == 0));
    end

    // Plan 2: change to 4 mid-period
    wait_count(3);
    offer(4);
    check("t2_ready_low", 32'(o_limit_ready), 32'd0);
    check("t2_count", 32'(o_count), 32'd4);
    wait_count(0);
    check("t2_applied", 32'(o_active_limit), 32'd4);
    check("t2_ready_back", 32'(o_limit_ready), 32'd1);
    check("t2_pulse", 32'(o_roll_over), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t2_period5", 32'(o_roll_over), 32'(k == 5));
    end

    // Plan 3: offer 2 exactly on the wrap cycle
    wait_count(4);
    offer(2);
    check("t3_old_active", 32'(o_active_limit), 32'd4);
    check("t3_wrap_pulse", 32'(o_roll_over), 32'd1);
    for (int k = 0; k < 20; k++) step();
    check("t3_new_active", 32'(o_active_limit), 32'd2);

    // Plan 4: limit 0 gives a continuous pulse
    offer(0);
    for (int k = 0; k < 8; k++) step();
    check("t4_active0", 32'(o_active_limit), 32'd0);
    check("t4_roll_hi", 32'(o_roll_over), 32'd1);
    check("t4_count0", 32'(o_count), 32'd0);
    i_enable = 1'b0;
    step();
    check("t4_roll_drop", 32'(o_roll_over), 32'd0);

    // Plan 5: hold while disabled, then idle apply
    i_enable = 1'b1;
    offer(9);
    wait_count(5);
    i_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_hold", 32'(o_count), 32'd5);
    end
    offer(7);
    step();
    check("t5_idle_count", 32'(o_count), 32'd0);
    check("t5_idle_active", 32'(o_active_limit), 32'd7);
    check("t5_idle_nopulse", 32'(o_roll_over), 32'd0);
    i_enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t5_first_pulse", 32'(o_roll_over), 32'(k == 8));
    end

    // Plan 6: reset with a pending limit discards it
    wait_count(1);
    offer(3);
    wait_count(6);
    check("t6_pending", 32'(o_limit_ready), 32'd0);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("t6_count", 32'(o_count), 32'd0);
    check("t6_active", 32'(o_active_limit), 32'(RESET_LIMIT));
    check("t6_ready", 32'(o_limit_ready), 32'd1);
    for (int k = 0; k < 25; k++) step();
    check("t6_not_applied", 32'(o_active_limit), 32'(RESET_LIMIT));

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      i_reset       = ($urandom_range(0, 199) == 0);
      i_enable      = ($urandom_range(0, 9) < 8);
      i_limit_valid = ($urandom_range(0, 9) < 2);
      i_limit       = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
